dma_xfer_splitter: RTL and testbench
====================================

Name: dma_xfer_splitter

Overview:
Transaction-to-transfer splitter that sits directly upstream of the read/write transfer queues. It accepts one user transaction: source address, destination address and a 32-bit byte count. It emits a sequence of transfer commands with a 12-bit byte count and source/destination addresses. No transfer crosses a 4 KiB page on either the source or the destination side, and no transfer exceeds MAX_XFER_BYTES.

Parameters:
MAX_XFER_BYTES, 2048, upper bound on bytes per emitted transfer; legal range 1..4095 (must fit the 12-bit NumBytes field).
PAGE_BYTES, 4096, boundary no transfer may cross; power of two, 2..4096.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
trans_valid  in  1  transaction command valid
trans_ready  out  1  splitter can accept a transaction
trans_src_addr  in  32  transaction source byte address
trans_dst_addr  in  32  transaction destination byte address
trans_num_bytes  in  32  transaction length in bytes
xfer_valid  out  1  transfer command valid
xfer_ready  in  1  downstream accepts transfer
xfer_num_bytes  out  12  transfer length in bytes
xfer_src_addr  out  32  transfer source address
xfer_dst_addr  out  32  transfer destination address
xfer_last  out  1  final transfer of the current transaction
done  out  1  one-cycle pulse when a transaction completes
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0, except trans_ready = 1. State = IDLE, internal registers cleared.
- States: IDLE, CALC, ISSUE.
- IDLE:
  - trans_ready = 1.
  - A handshake (trans_valid & trans_ready) registers src, dst and remaining = trans_num_bytes.
  - Next state is CALC if trans_num_bytes != 0.
  - A zero-length transaction stays in IDLE, pulses done on the following cycle and emits no transfer.
- CALC:
  - Registers chunk = min(remaining, MAX_XFER_BYTES, PAGE_BYTES - (src mod PAGE_BYTES), PAGE_BYTES - (dst mod PAGE_BYTES)).
  - Registers xfer_last = (chunk == remaining).
  - Always moves to ISSUE after one cycle.
- ISSUE:
  - xfer_valid = 1.
  - xfer_* hold stable until xfer_ready is seen; xfer_valid never drops without a handshake.
  - On handshake: src += chunk, dst += chunk (both modulo 2^32; wrap is legal), remaining -= chunk.
  - If xfer_last: done pulses the next cycle and state goes to IDLE. Otherwise state goes to CALC.
- Latency and throughput:
  - First xfer_valid is 2 cycles after the trans handshake.
  - One transfer per 2 cycles with xfer_ready held high.
  - The next transaction is accepted on the cycle done is high (back in IDLE).
- trans_ready = 0 in CALC and ISSUE. A transaction is never accepted while one is in flight.
- Arithmetic: chunk is always in 1..MAX_XFER_BYTES, so it fits 12 bits. Page-offset math uses the low log2(PAGE_BYTES) bits only.
- Reset mid-transaction: the in-flight transaction is discarded. No done, no further transfers. Outputs return to reset values on the next edge.
- xfer_last is meaningful only while xfer_valid = 1; it is 0 otherwise.

Optional Feature:
DMA_SPLIT_STATS_EN
- Defined:
  - Adds output xfer_count (16 bits): transfers emitted for the current transaction. It clears on trans handshake, increments on each xfer handshake, and holds its value after done until the next accept. Reset value 0.
  - Adds output trans_count (32 bits): completed transactions, incremented on each done pulse, including zero-length transactions. Wraps at 2^32. Reset value 0.
- Undefined: neither port exists and no counter logic is present. All other behaviour is identical.

Test Plan:
- Aligned short transaction: src=0x1000, dst=0x2000, len=100 -> one transfer (100, 0x1000, 0x2000), last=1. done pulses 1 cycle after the xfer handshake.
- Source page cross: src=0x0FF0, dst=0x3000, len=64 -> transfers (16, 0x0FF0, 0x3000) then (48, 0x1000, 0x3010), last=1 on the second only.
- Mixed boundaries: src=0x0800, dst=0x0F00, len=4096 -> transfers of 256, 1792 and 2048 bytes:
  - (256, 0x0800, 0x0F00)
  - (1792, 0x0900, 0x1000)
  - (2048, 0x1000, 0x1700), last=1
- Max-size split: src=0, dst=0, len=5000 -> 2048, 2048, 904; last=1 on the third only. Address wrap case: src=0xFFFFFF00, len=512 -> (256, 0xFFFFFF00) then (256, 0x00000000).
- Zero length and backpressure:
  - len=0 -> no xfer_valid; done 1 cycle after accept.
  - xfer_ready held low 5 cycles during a transfer -> xfer_* and xfer_valid stable throughout; trans_ready = 0.
- Reset mid-operation: assert rst while in ISSUE of a 3-transfer transaction -> next cycle xfer_valid=0, trans_ready=1, no done. A subsequent 100-byte transaction completes normally, and with DMA_SPLIT_STATS_EN, trans_count=1.

Source files
------------

// File: rtl/dma_xfer_splitter.sv
// Splits one DMA transaction into transfers that never cross a page on either side and never exceed MAX_XFER_BYTES.
// Latency: first xfer_valid 2 cycles after the transaction handshake; one transfer per 2 cycles with xfer_ready high.
// Backpressure: xfer_* held stable while xfer_ready is low; trans_ready is low until the transaction completes.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   trans_valid/trans_ready  transaction handshake; trans_src_addr, trans_dst_addr, trans_num_bytes payload
//   xfer_valid/xfer_ready    transfer handshake; xfer_num_bytes, xfer_src_addr, xfer_dst_addr, xfer_last payload
//   done                     one-cycle pulse after the final transfer (or after accepting a zero-length transaction)
//   busy                     high while a transaction is being split
//   xfer_count, trans_count  per-transaction transfer count and completed-transaction count;
//                            present only when DMA_SPLIT_STATS_EN is defined
module dma_xfer_splitter #(
  parameter int MAX_XFER_BYTES = 2048,
  parameter int PAGE_BYTES     = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trans_valid,
  output logic        trans_ready,
  input  logic [31:0] trans_src_addr,
  input  logic [31:0] trans_dst_addr,
  input  logic [31:0] trans_num_bytes,
  output logic        xfer_valid,
  input  logic        xfer_ready,
  output logic [11:0] xfer_num_bytes,
  output logic [31:0] xfer_src_addr,
  output logic [31:0] xfer_dst_addr,
  output logic        xfer_last,
  output logic        done,
  output logic        busy
`ifdef DMA_SPLIT_STATS_EN
  ,
  output logic [15:0] xfer_count,
  output logic [31:0] trans_count
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  // Page offsets only ever need the low 12 bits since PAGE_BYTES <= 4096.
  localparam logic [11:0] PAGE_MASK = 12'(PAGE_BYTES - 1);
  localparam logic [12:0] PAGE_SZ   = 13'(PAGE_BYTES);
  localparam logic [11:0] MAX_LIM   = 12'(MAX_XFER_BYTES);

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] rem_q, rem_d;
  logic [11:0] chunk_q, chunk_d;
  logic        last_q, last_d;
  logic        done_q, done_d;

  logic [12:0] src_room, dst_room;
  logic [11:0] lim;
  logic        trans_hs, xfer_hs;

  assign trans_ready    = (state_q == IDLE);
  assign xfer_valid     = (state_q == ISSUE);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign xfer_num_bytes = chunk_q;
  assign xfer_src_addr  = src_q;
  assign xfer_dst_addr  = dst_q;
  assign xfer_last      = last_q & xfer_valid;

  assign trans_hs = trans_valid & trans_ready;
  assign xfer_hs  = xfer_valid & xfer_ready;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    chunk_d  = chunk_q;
    last_d   = last_q;
    done_d   = 1'b0;

    // Bytes left before the next page boundary on each side (1..PAGE_BYTES).
    src_room = PAGE_SZ - {1'b0, src_q[11:0] & PAGE_MASK};
    dst_room = PAGE_SZ - {1'b0, dst_q[11:0] & PAGE_MASK};

    // Narrow the limit step by step; once below MAX_LIM every candidate fits 12 bits.
    lim = MAX_LIM;
    if ({1'b0, lim} > src_room) lim = src_room[11:0];
    if ({1'b0, lim} > dst_room) lim = dst_room[11:0];
    if ({20'b0, lim} > rem_q)   lim = rem_q[11:0];

    case (state_q)
      IDLE: begin
        if (trans_hs) begin
          src_d = trans_src_addr;
          dst_d = trans_dst_addr;
          rem_d = trans_num_bytes;
          if (trans_num_bytes != 32'd0) state_d = CALC;
          else                          done_d  = 1'b1;
        end
      end
      CALC: begin
        chunk_d = lim;
        last_d  = ({20'b0, lim} == rem_q);
        state_d = ISSUE;
      end
      ISSUE: begin
        if (xfer_hs) begin
          src_d = src_q + {20'b0, chunk_q};
          dst_d = dst_q + {20'b0, chunk_q};
          rem_d = rem_q - {20'b0, chunk_q};
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef DMA_SPLIT_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;
  logic [31:0] trans_count_q, trans_count_d;

  always_comb begin
    xfer_count_d  = xfer_count_q;
    trans_count_d = trans_count_q;
    if (trans_hs)     xfer_count_d  = 16'd0;
    else if (xfer_hs) xfer_count_d  = xfer_count_q + 16'd1;
    if (done_q)       trans_count_d = trans_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q  <= '0;
      trans_count_q <= '0;
    end else begin
      xfer_count_q  <= xfer_count_d;
      trans_count_q <= trans_count_d;
    end
  end

  assign xfer_count  = xfer_count_q;
  assign trans_count = trans_count_q;
`endif

endmodule

// File: tb/tb_dma_xfer_splitter.sv
// Bench for dma_xfer_splitter: directed cases followed by random transactions checked against a reference model.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
module tb_dma_xfer_splitter;

  localparam logic [31:0] MAXV  = 32'd2048;
  localparam logic [31:0] PAGEV = 32'd4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        trans_valid;
  logic        trans_ready;
  logic [31:0] trans_src_addr;
  logic [31:0] trans_dst_addr;
  logic [31:0] trans_num_bytes;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [11:0] xfer_num_bytes;
  logic [31:0] xfer_src_addr;
  logic [31:0] xfer_dst_addr;
  logic        xfer_last;
  logic        done;
  logic        busy;
`ifdef DMA_SPLIT_STATS_EN
  logic [15:0] xfer_count;
  logic [31:0] trans_count;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int exp_tc  = 0;

  // Expected transfers of the current transaction.
  logic [31:0] q_n[$];
  logic [31:0] q_s[$];
  logic [31:0] q_d[$];
  logic        q_l[$];

  dma_xfer_splitter #(.MAX_XFER_BYTES(2048), .PAGE_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .trans_valid(trans_valid), .trans_ready(trans_ready),
    .trans_src_addr(trans_src_addr), .trans_dst_addr(trans_dst_addr),
    .trans_num_bytes(trans_num_bytes),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
    .xfer_num_bytes(xfer_num_bytes), .xfer_src_addr(xfer_src_addr),
    .xfer_dst_addr(xfer_dst_addr), .xfer_last(xfer_last),
    .done(done), .busy(busy)
`ifdef DMA_SPLIT_STATS_EN
    , .xfer_count(xfer_count), .trans_count(trans_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference split: repeatedly take the largest chunk allowed by the remaining length,
  // the size cap and the distance to the next page boundary on both sides.
  task automatic model(input logic [31:0] s_in, input logic [31:0] d_in, input logic [31:0] len);
    logic [31:0] s, d, rem, c, ps, pd;
    q_n.delete(); q_s.delete(); q_d.delete(); q_l.delete();
    s = s_in; d = d_in; rem = len;
    while (rem != 0) begin
      ps = PAGEV - (s % PAGEV);
      pd = PAGEV - (d % PAGEV);
      c = rem;
      if (c > MAXV) c = MAXV;
      if (c > ps)   c = ps;
      if (c > pd)   c = pd;
      q_n.push_back(c); q_s.push_back(s); q_d.push_back(d);
      rem = rem - c;
      q_l.push_back(rem == 0);
      s = s + c;
      d = d + c;
    end
  endtask

  task automatic chk_stats(input string nm, input int xc);
`ifdef DMA_SPLIT_STATS_EN
    chk({nm, " xfer_count"}, {16'b0, xfer_count}, 32'(xc));
    chk({nm, " trans_count"}, trans_count, 32'(exp_tc));
`else
    if (nm.len() < 0 || xc < 0) $display("unused");
`endif
  endtask

  task automatic run_trans(input logic [31:0] s, input logic [31:0] d, input logic [31:0] len,
                           input int stall, input string nm);
    int w;
    model(s, d, len);
    chk1({nm, " trans_ready idle"}, trans_ready, 1'b1);
    trans_valid = 1'b1; trans_src_addr = s; trans_dst_addr = d; trans_num_bytes = len;
    step();
    trans_valid = 1'b0;
    if (q_n.size() == 0) begin
      chk1({nm, " zero done"}, done, 1'b1);
      chk1({nm, " zero xfer_valid"}, xfer_valid, 1'b0);
      chk1({nm, " zero trans_ready"}, trans_ready, 1'b1);
      exp_tc++;
      step();
      chk_stats(nm, 0);
    end
    for (int i = 0; i < q_n.size(); i++) begin
      chk1({nm, " busy"}, busy, 1'b1);
      chk1({nm, " calc no valid"}, xfer_valid, 1'b0);
      chk1({nm, " calc last low"}, xfer_last, 1'b0);
      step();
      chk1({nm, " valid after 1 calc cycle"}, xfer_valid, 1'b1);
      w = 0;
      while (xfer_valid !== 1'b1 && w < 8) begin
        step();
        w++;
      end
      if (xfer_valid !== 1'b1) begin
        chk1({nm, " xfer_valid timeout"}, xfer_valid, 1'b1);
        return;
      end
      chk({nm, " num_bytes"}, {20'b0, xfer_num_bytes}, q_n[i]);
      chk({nm, " src"}, xfer_src_addr, q_s[i]);
      chk({nm, " dst"}, xfer_dst_addr, q_d[i]);
      chk1({nm, " last"}, xfer_last, q_l[i]);
      chk1({nm, " trans_ready in issue"}, trans_ready, 1'b0);
      for (int k = 0; k < stall; k++) begin
        step();
        chk1({nm, " stall valid"}, xfer_valid, 1'b1);
        chk({nm, " stall num"}, {20'b0, xfer_num_bytes}, q_n[i]);
        chk({nm, " stall src"}, xfer_src_addr, q_s[i]);
        chk({nm, " stall dst"}, xfer_dst_addr, q_d[i]);
        chk1({nm, " stall last"}, xfer_last, q_l[i]);
        chk1({nm, " stall trans_ready"}, trans_ready, 1'b0);
      end
      xfer_ready = 1'b1;
      step();
      xfer_ready = 1'b0;
      if (q_l[i]) begin
        chk1({nm, " done after last"}, done, 1'b1);
        chk1({nm, " trans_ready after last"}, trans_ready, 1'b1);
        chk1({nm, " valid drops after last"}, xfer_valid, 1'b0);
        exp_tc++;
        step();
        chk1({nm, " done one pulse"}, done, 1'b0);
        chk_stats(nm, i + 1);
      end else begin
        chk1({nm, " no done mid"}, done, 1'b0);
`ifdef DMA_SPLIT_STATS_EN
        chk({nm, " xfer_count mid"}, {16'b0, xfer_count}, 32'(i + 1));
`endif
      end
    end
  endtask

  initial begin
    logic [31:0] s, d, len;
    rst = 1'b1; trans_valid = 1'b0; xfer_ready = 1'b0;
    trans_src_addr = '0; trans_dst_addr = '0; trans_num_bytes = '0;
    repeat (3) step();
    chk1("rst trans_ready", trans_ready, 1'b1);
    chk1("rst xfer_valid", xfer_valid, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst xfer_last", xfer_last, 1'b0);
    chk("rst num_bytes", {20'b0, xfer_num_bytes}, 32'd0);
    chk("rst src", xfer_src_addr, 32'd0);
    chk("rst dst", xfer_dst_addr, 32'd0);
    chk_stats("rst", 0);
    rst = 1'b0;
    step();

    run_trans(32'h0000_1000, 32'h0000_2000, 32'd100,  0, "aligned");
    run_trans(32'h0000_0FF0, 32'h0000_3000, 32'd64,   0, "src_cross");
    run_trans(32'h0000_0800, 32'h0000_0F00, 32'd4096, 0, "mixed");
    run_trans(32'h0000_0000, 32'h0000_0000, 32'd5000, 0, "max_split");
    run_trans(32'hFFFF_FF00, 32'h0000_0000, 32'd512,  0, "wrap");
    run_trans(32'h0000_0100, 32'h0000_0200, 32'd0,    0, "zero");
    run_trans(32'h0000_5000, 32'h0000_6000, 32'd300,  5, "backpressure");

    for (int t = 0; t < 25; t++) begin
      s = $urandom();
      d = $urandom();
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_F000 | {20'b0, 12'($urandom_range(0, 4095))};
      case ($urandom_range(0, 3))
        0:       len = 32'($urandom_range(0, 64));
        1:       len = 32'($urandom_range(1, 5000));
        2:       len = 32'($urandom_range(4000, 12000));
        default: len = 32'd0;
      endcase
      run_trans(s, d, len, $urandom_range(0, 2), "random");
    end

    // Reset while the second of three transfers is being offered.
    model(32'd0, 32'd0, 32'd5000);
    trans_valid = 1'b1; trans_src_addr = 32'd0; trans_dst_addr = 32'd0; trans_num_bytes = 32'd5000;
    step();
    trans_valid = 1'b0;
    step();
    chk1("mid first valid", xfer_valid, 1'b1);
    xfer_ready = 1'b1;
    step();
    xfer_ready = 1'b0;
    step();
    chk1("mid second valid", xfer_valid, 1'b1);
    chk("mid second src", xfer_src_addr, q_s[1]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_tc = 0;
    chk1("mid rst xfer_valid", xfer_valid, 1'b0);
    chk1("mid rst trans_ready", trans_ready, 1'b1);
    chk1("mid rst done", done, 1'b0);
    chk1("mid rst busy", busy, 1'b0);
    step();
    chk1("mid rst no late done", done, 1'b0);
    chk1("mid rst stays idle", xfer_valid, 1'b0);
    run_trans(32'h0000_1000, 32'h0000_2000, 32'd100, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
